// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes,
// a registered terminal-count pulse and a sticky done/ack handshake.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic             at_zero;
  logic             at_one;

  assign at_zero = (count == ZERO);
  assign at_one  = (count == ONE);

  // busy/done decode the state directly so they track it with no lag
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= ZERO;
      reload_reg <= ZERO;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count      <= load_data;
        reload_reg <= load_data;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (at_zero) begin
                state <= DONE;
                tc    <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            if (!pause) begin
              // a zero count here can only come from a load while running
              if (at_zero) begin
                state <= DONE;
                tc    <= 1'b1;
              end else if (at_one) begin
                tc <= 1'b1;
                if (auto_reload) begin
                  count <= reload_reg;
                end else begin
                  count <= ZERO;
                  state <= DONE;
                end
              end else begin
                count <= count - ONE;
              end
            end
          end
          DONE: begin
            if (ack) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: vector table plus corner-case
// sequences, expectations queued at drive time and popped at sample time.
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_data;
  logic         start;
  logic         auto_reload;
  logic         pause;
  logic         ack;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         tc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] c;
    logic         b;
    logic         d;
    logic         t;
    string        name;
  } exp_t;

  typedef struct {
    logic         ld;
    logic [W-1:0] dat;
    logic         st;
    logic         ar;
    logic         ps;
    logic         ak;
    logic [W-1:0] c;
    logic         b;
    logic         d;
    logic         t;
    string        name;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[16];

  down_counter_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (load_data),
    .start      (start),
    .auto_reload(auto_reload),
    .pause      (pause),
    .ack        (ack),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic ld, logic [W-1:0] dat, logic st,
                              logic ar, logic ps, logic ak,
                              logic [W-1:0] c, logic b, logic d,
                              logic t, string name);
    vec_t v;
    v.ld = ld; v.dat = dat; v.st = st; v.ar = ar; v.ps = ps; v.ak = ak;
    v.c = c; v.b = b; v.d = d; v.t = t; v.name = name;
    return v;
  endfunction

  task automatic push(logic [W-1:0] c, logic b, logic d, logic t,
                      string name);
    exp_t e;
    e.c = c; e.b = b; e.d = d; e.t = t; e.name = name;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (count !== e.c || busy !== e.b || done !== e.d || tc !== e.t) begin
      errors++;
      $display("FAIL %s: got count=%0d busy=%b done=%b tc=%b, want count=%0d busy=%b done=%b tc=%b",
               e.name, count, busy, done, tc, e.c, e.b, e.d, e.t);
    end
  endtask

  task automatic step(logic ld, logic [W-1:0] dat, logic st, logic ar,
                      logic ps, logic ak, logic [W-1:0] c, logic b,
                      logic d, logic t, string name);
    load = ld; load_data = dat; start = st;
    auto_reload = ar; pause = ps; ack = ak;
    push(c, b, d, t, name);
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic pulse_reset(string name);
    #2 reset = 1'b1;
    #1;
    push('0, 1'b0, 1'b0, 1'b0, name);
    check();
    #1 reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1, 3, 0, 0, 0, 0, 3, 0, 0, 0, "os_load3");
    tbl[1]  = mk(0, 0, 1, 0, 0, 0, 3, 1, 0, 0, "os_start");
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, "os_dec2");
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, "os_dec1");
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "os_expire");
    tbl[5]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, "os_tc_low");
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "os_ack");
    tbl[7]  = mk(1, 2, 0, 0, 0, 0, 2, 0, 0, 0, "ar_load2");
    tbl[8]  = mk(0, 0, 1, 1, 0, 0, 2, 1, 0, 0, "ar_start");
    tbl[9]  = mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, "ar_dec1a");
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 2, 1, 0, 1, "ar_reload_a");
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, "ar_dec1b");
    tbl[12] = mk(0, 0, 0, 1, 0, 0, 2, 1, 0, 1, "ar_reload_b");
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, "ar_off_dec");
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "ar_off_expire");
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "ar_ack");

    reset = 1'b1;
    load = 0; load_data = '0; start = 0;
    auto_reload = 0; pause = 0; ack = 0;
    #3;
    push('0, 1'b0, 1'b0, 1'b0, "reset_state");
    check();
    #9 reset = 1'b0;

    for (int i = 0; i < 16; i++)
      step(tbl[i].ld, tbl[i].dat, tbl[i].st, tbl[i].ar, tbl[i].ps,
           tbl[i].ak, tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].t,
           tbl[i].name);

    // pause holds count and suppresses tc
    step(1, 5, 0, 0, 0, 0, 5, 0, 0, 0, "pa_load5");
    step(0, 0, 1, 0, 0, 0, 5, 1, 0, 0, "pa_start");
    step(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, "pa_dec4");
    step(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, "pa_dec3");
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 1, 0, 3, 1, 0, 0, "pa_hold");
    step(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, "pa_dec2");
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, "pa_dec1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "pa_expire");
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "pa_ack");

    // load while running, then load of zero while running
    step(1, 6, 0, 0, 0, 0, 6, 0, 0, 0, "lm_load6");
    step(0, 0, 1, 0, 0, 0, 6, 1, 0, 0, "lm_start");
    step(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, "lm_dec5");
    step(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, "lm_dec4");
    step(1, 2, 0, 0, 0, 0, 2, 1, 0, 0, "lm_load2");
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, "lm_dec1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "lm_expire");
    step(1, 9, 1, 0, 0, 0, 9, 0, 1, 0, "lm_load_in_done");
    step(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, "lm_ack");
    step(1, 3, 0, 0, 0, 0, 3, 0, 0, 0, "lz_load3");
    step(0, 0, 1, 1, 0, 0, 3, 1, 0, 0, "lz_start");
    step(0, 0, 0, 1, 0, 0, 2, 1, 0, 0, "lz_dec2");
    step(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, "lz_load0");
    step(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, "lz_expire");
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "lz_ack");

    // zero start straight to DONE, then async reset clears tc at once
    pulse_reset("zs_reset");
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "zs_start");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "zs_tc_low");
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "zs_ack");
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "zs_restart");
    pulse_reset("rst_clears_tc");

    // reset mid-run
    step(1, 5, 0, 0, 0, 0, 5, 0, 0, 0, "rm_load5");
    step(0, 0, 1, 0, 0, 0, 5, 1, 0, 0, "rm_start");
    step(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, "rm_dec4");
    step(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, "rm_dec3");
    pulse_reset("rm_reset");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rm_idle");
    step(1, 4, 0, 0, 0, 0, 4, 0, 0, 0, "rm_load4");
    step(0, 0, 1, 0, 0, 0, 4, 1, 0, 0, "rm_restart");
    step(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, "rm_dec3b");

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
